// File: rtl/pong_pkg.sv
// Shared definitions for the pong board: PMOD 1B pad map, dot-matrix pin
// order and the pmod_share_sched state encoding.
package pong_pkg;

    localparam int DM_PIN_W = 6;
    localparam int DIFF_W   = 4;
    localparam int PAD_W    = 8;

    // Bit positions inside the driver bundle {OEB, LE, CCLK, CSDI, RSDI, RCLK}
    localparam int DM_RCLK = 0;
    localparam int DM_RSDI = 1;
    localparam int DM_CSDI = 2;
    localparam int DM_CCLK = 3;
    localparam int DM_LE   = 4;
    localparam int DM_OEB  = 5;

    // Pads [3:0] double as dial bits [3:0]
    localparam int PAD_CCLK = 0;
    localparam int PAD_CSDI = 1;
    localparam int PAD_RSDI = 2;
    localparam int PAD_RCLK = 3;
    localparam int PAD_LE   = 4;
    localparam int PAD_OEB  = 5;

    localparam logic [PAD_W-1:0] PAD_OE_DRIVE  = 8'h3F;
    localparam logic [PAD_W-1:0] PAD_OE_FLOAT  = 8'h30;
    localparam logic [PAD_W-1:0] PAD_OUT_FLOAT = 8'h20;

    typedef enum logic [2:0] {
        ST_DM,
        ST_WAIT_IDLE,
        ST_FLOAT1,
        ST_SAMPLE1,
        ST_FLOAT2,
        ST_SAMPLE2,
        ST_RESTORE
    } pmod_share_state_t;

    function automatic logic [PAD_W-1:0] pad_map(
        input logic [DM_PIN_W-1:0] dm
    );
        logic [PAD_W-1:0] p;
        p           = '0;
        p[PAD_CCLK] = dm[DM_CCLK];
        p[PAD_CSDI] = dm[DM_CSDI];
        p[PAD_RSDI] = dm[DM_RSDI];
        p[PAD_RCLK] = dm[DM_RCLK];
        p[PAD_LE]   = dm[DM_LE];
        p[PAD_OEB]  = dm[DM_OEB];
        return p;
    endfunction

endpackage

// File: rtl/pmod_share_sched.sv
// Time-shares PMOD 1B between the dot-matrix driver and the difficulty dial.
// Define PMOD_SHARE_DEBOUNCE_EN to require two matching dial samples.
module pmod_share_sched
    import pong_pkg::*;
#(
    parameter int PERIOD = 315000,
    parameter int SETTLE = 32
) (
    input  logic                clk32mhz,
    input  logic                reset,
    input  logic                dm_busy,
    input  logic [DM_PIN_W-1:0] dm_pins,
    output logic                dm_grant,
    input  logic [PAD_W-1:0]    pmod_in,
    output logic [PAD_W-1:0]    pmod_out,
    output logic [PAD_W-1:0]    pmod_oe,
    output logic [DIFF_W-1:0]   difficulty,
    output logic                difficulty_valid
);

    localparam int PCNT_W = $clog2(PERIOD);
    localparam int SCNT_W = $clog2(SETTLE + 1);

    localparam logic [PCNT_W-1:0] PCNT_LAST = PCNT_W'(PERIOD - 1);
    localparam logic [PCNT_W-1:0] PCNT_ONE  = PCNT_W'(1);
    localparam logic [SCNT_W-1:0] SCNT_LAST = SCNT_W'(SETTLE - 1);
    localparam logic [SCNT_W-1:0] SCNT_ONE  = SCNT_W'(1);

    pmod_share_state_t   r_state;
    logic [PCNT_W-1:0]   r_pcnt;
    logic [SCNT_W-1:0]   r_scnt;
    logic [DIFF_W-1:0]   r_diff;
    logic                r_valid;
    logic                r_grant;
    logic [PAD_W-1:0]    r_out;
    logic [PAD_W-1:0]    r_oe;
`ifdef PMOD_SHARE_DEBOUNCE_EN
    logic [DIFF_W-1:0]   r_s1;
`endif

    logic                w_float;
    logic [DIFF_W-1:0]   w_dial;
    logic                w_unused_pads;

    assign w_dial        = pmod_in[DIFF_W-1:0];
    assign w_unused_pads = ^pmod_in[PAD_W-1:DIFF_W];

    // Shared pins stay released through the sample cycles too
    assign w_float = (r_state == ST_FLOAT1)  ||
                     (r_state == ST_SAMPLE1) ||
                     (r_state == ST_FLOAT2)  ||
                     (r_state == ST_SAMPLE2);

    always_ff @(posedge clk32mhz) begin
        if (reset) begin
            r_state <= ST_FLOAT1;
            r_pcnt  <= '0;
            r_scnt  <= '0;
            r_diff  <= '0;
            r_valid <= 1'b0;
            r_grant <= 1'b0;
            r_out   <= PAD_OUT_FLOAT;
            r_oe    <= PAD_OE_FLOAT;
`ifdef PMOD_SHARE_DEBOUNCE_EN
            r_s1    <= '0;
`endif
        end else begin
            r_valid <= 1'b0;
            r_out   <= w_float ? PAD_OUT_FLOAT : pad_map(dm_pins);
            r_oe    <= w_float ? PAD_OE_FLOAT : PAD_OE_DRIVE;

            unique case (r_state)
                ST_DM: begin
                    if (r_pcnt == PCNT_LAST) begin
                        r_state <= ST_WAIT_IDLE;
                        r_pcnt  <= '0;
                        r_grant <= 1'b0;
                    end else begin
                        r_pcnt <= r_pcnt + PCNT_ONE;
                    end
                end
                ST_WAIT_IDLE: begin
                    if (!dm_busy) begin
                        r_state <= ST_FLOAT1;
                        r_scnt  <= '0;
                    end
                end
                ST_FLOAT1: begin
                    if (r_scnt == SCNT_LAST) begin
                        r_state <= ST_SAMPLE1;
                        r_scnt  <= '0;
                    end else begin
                        r_scnt <= r_scnt + SCNT_ONE;
                    end
                end
                ST_SAMPLE1: begin
`ifdef PMOD_SHARE_DEBOUNCE_EN
                    r_s1    <= w_dial;
                    r_state <= ST_FLOAT2;
                    r_scnt  <= '0;
`else
                    r_diff  <= w_dial;
                    r_valid <= 1'b1;
                    r_state <= ST_RESTORE;
`endif
                end
`ifdef PMOD_SHARE_DEBOUNCE_EN
                ST_FLOAT2: begin
                    if (r_scnt == SCNT_LAST) begin
                        r_state <= ST_SAMPLE2;
                        r_scnt  <= '0;
                    end else begin
                        r_scnt <= r_scnt + SCNT_ONE;
                    end
                end
                ST_SAMPLE2: begin
                    // A dial caught mid-turn gives two different readings
                    if (w_dial == r_s1) begin
                        r_diff  <= w_dial;
                        r_valid <= 1'b1;
                    end
                    r_state <= ST_RESTORE;
                end
`endif
                ST_RESTORE: begin
                    r_state <= ST_DM;
                    r_pcnt  <= '0;
                    r_grant <= 1'b1;
                end
                default: begin
                    r_state <= ST_FLOAT1;
                    r_scnt  <= '0;
                    r_grant <= 1'b0;
                end
            endcase
        end
    end

    assign dm_grant         = r_grant;
    assign pmod_out         = r_out;
    assign pmod_oe          = r_oe;
    assign difficulty       = r_diff;
    assign difficulty_valid = r_valid;

endmodule

// File: doc/pmod_share_sched.md
# pmod_share_sched

Time-shares PMOD 1B between the dot-matrix display driver (output) and the 4-bit difficulty dial (input) so the board can run VGA, dial and dot matrix together. Sits between `pong`'s dot-matrix pins and the top-level PMOD pads in `fpga`. The dot-matrix driver owns the bus by default. Every `PERIOD` cycles the scheduler reclaims it at a transaction boundary, floats the shared pins, samples the dial, then hands the bus back.

## Interface
- `PERIOD`, 315000, cycles between dial sample windows (~10 ms at 31.5 MHz); ≥ 16
- `SETTLE`, 32, cycles the pins float before each dial sample; ≥ 2
- `clk32mhz` in 1: pixel/system clock
- `reset` in 1: synchronous, active-high
- `dm_busy` in 1: driver mid-transaction (shift + latch); must not be preempted
- `dm_pins` in 6: {OEB, LE, CCLK, CSDI, RSDI, RCLK} from the driver
- `dm_grant` out 1: driver may start a new transaction
- `pmod_in` in 8: pad input values
- `pmod_out` out 8: pad output values
- `pmod_oe` out 8: pad output enables
- `difficulty` out 4: last accepted dial value
- `difficulty_valid` out 1: one-cycle pulse on each accepted sample, even if the value is unchanged

## Operation
- Pin map:
  - pads [3:0] = RCLK, RSDI, CSDI, CCLK, shared with dial bits [3:0]
  - pad 4 = LE, dedicated
  - pad 5 = OEB, dedicated
  - pads [7:6]: oe=0, out=0
- FSM states: DM, WAIT_IDLE, FLOAT1, SAMPLE1, FLOAT2, SAMPLE2, RESTORE.
- DM: `dm_grant`=1, all six pins driven from `dm_pins`, period counter counting. Counter at `PERIOD`-1 → WAIT_IDLE, counter cleared.
- WAIT_IDLE: `dm_grant`=0. Pins still follow `dm_pins`. `dm_busy` is evaluated from the cycle after entry. Once `dm_busy`=0 → FLOAT1. Wait is unbounded.
- FLOAT1: oe[3:0]=0, OEB forced 1 (blank), LE forced 0, settle counter runs. After `SETTLE` cycles → SAMPLE1.
- SAMPLE1: capture `pmod_in[3:0]` into s1 → FLOAT2.
- FLOAT2: same pin state as FLOAT1, `SETTLE` cycles → SAMPLE2.
- SAMPLE2: if `pmod_in[3:0]`==s1, load `difficulty` and pulse `difficulty_valid`; else keep the old value and give no pulse. → RESTORE.
- RESTORE: one cycle. Pins driven from `dm_pins`, `dm_grant` still 0. → DM, where grant rises.
- Driver rule: it may raise `dm_busy` only in a cycle where it sampled `dm_grant`=1. A busy raised on the same edge that grant falls is legal and is waited out.
- Counters: period counter width = clog2(`PERIOD`); settle counter width = clog2(`SETTLE`+1). Both saturate-free and cleared on state entry.

## Timing
- Reset values:
  - state = FLOAT1, so the first sample window starts immediately after reset
  - `dm_grant`=0, `pmod_oe`=8'h30 (pads 4–5 driven), `pmod_out`=8'h20 (OEB=1)
  - `difficulty`=0, `difficulty_valid`=0, counters 0
- Reset in any state returns to the reset values on the next edge. A window interrupted by reset discards s1.
- All outputs are registered. `pmod_out`/`pmod_oe` change on the edge after the state transition.
- Window length with `dm_busy` already low: 1 (WAIT_IDLE) + 2×`SETTLE` + 2 + 1 = 2×`SETTLE`+4 cycles of `dm_grant`=0.
- Sample points: s1 uses the pad value present in the `SETTLE`-th float cycle + 1. The second sample is taken `SETTLE`+1 cycles later.
- First `difficulty_valid` after reset release: cycle 2×`SETTLE`+2, provided the dial is stable.
- The period counter does not run outside DM.

## Configuration
- `PMOD_SHARE_DEBOUNCE_EN` defined: two-sample match as above.
- Not defined: FLOAT2/SAMPLE2 are removed. SAMPLE1 loads `difficulty` and pulses valid unconditionally, then → RESTORE. Window = `SETTLE`+3 cycles.

## Structure
- Shared package `pong_pkg`:
  - state enum `pmod_share_state_t`
  - pad index constants (`PAD_RCLK`…`PAD_OEB`)
  - `DM_PIN_W`=6, `DIFF_W`=4
- No sub-module needed. One optional `pmod_pad_mux` (combinational pin map) may be factored out but is not required.

## Test plan
- Reset release with `pmod_in`=8'h0B static, `SETTLE`=4 → `dm_grant`=0 until window end; `difficulty`=4'hB and a single `difficulty_valid` pulse at cycle 10; OEB pad=1 throughout.
- `PERIOD`=64, `dm_busy` held 1 for 20 cycles starting at the cycle grant falls → pads [3:0] keep following `dm_pins` and stay driven until 1 cycle after busy drops, then oe[3:0]=0.
- Dial changes 5→9 between SAMPLE1 and SAMPLE2 (debounce on) → `difficulty` stays 5, no pulse. Next window with 9 stable → 9 with pulse.
- Same stimulus with `PMOD_SHARE_DEBOUNCE_EN` undefined → `difficulty`=5 after the first window, 9 after the next; window length `SETTLE`+3.
- Reset asserted mid-FLOAT2 → next edge shows the reset values. Old `difficulty` is cleared to 0 and a fresh window starts.
- Idle driver, `PERIOD`=64, `SETTLE`=4 → windows repeat exactly every 64+12 cycles; `pmod_oe[7:6]` is always 0.
